vga_scanout: RTL and testbench
==============================

Name: vga_scanout

Overview:
- Display-side reader for the 14-bit x 32-bit VRAM that the CPU writes through the vga block.
- Generates 640x480@60 raster timing and fetches one VRAM word per 32 pixels through the VRAM read port.
- Serialises each word as 1 bpp pixels and outputs HSYNC, VSYNC, DE and PIXEL for the DAC/connector.
- CLK is the pixel clock. The CPU side uses every cycle in which N_OE is high.

Parameters:
- H_ACTIVE, 640, visible pixels per line; must be a multiple of 32.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, horizontal sync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width.
- V_BP, 33, vertical back porch.
- SYNC_POL, 0, active level of HSYNC/VSYNC.
- BASE_ADDR, 0, VRAM word address of pixel (0,0). BASE_ADDR + V_ACTIVE*H_ACTIVE/32 must be <= 16384.

Ports:
- CLK  in  1  pixel clock.
- N_RST  in  1  reset, synchronous, active-high.
- ADDR  out  14  VRAM read word address.
- N_OE  out  1  VRAM read strobe, active low.
- RD_DATA  in  32  VRAM read data; valid the cycle after N_OE=0.
- HSYNC  out  1  horizontal sync.
- VSYNC  out  1  vertical sync.
- DE  out  1  active-video enable.
- PIXEL  out  1  pixel value.
- VBLANK  out  1  high while the displayed line is >= V_ACTIVE; for CPU frame sync.
- FRAME_START  out  1  one-cycle pulse with pixel (0,0).

Behaviour:
- Totals: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (800); V_TOTAL likewise (525). WPL = H_ACTIVE/32 (20).
- Stage 0 counters:
  - h counts 0..H_TOTAL-1 and wraps to 0. On wrap, v increments, wrapping at V_TOTAL-1 -> 0.
  - active0 = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hs0 = (H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC); vs0 uses the same rule on v.
- Fetch, stage 0:
  - When active0 && h[4:0]==0: N_OE=0 and ADDR = row_addr + (h>>5).
  - Otherwise N_OE=1 and ADDR holds its last value.
  - row_addr is reset to BASE_ADDR at frame wrap and increments by WPL at the end of each active line (h==H_TOTAL-1, v<V_ACTIVE). No multiplier.
- Stage 1: RD_DATA is captured into a 32-bit shift register on the cycle after the fetch. The register shifts right by 1 on each other cycle.
- Stage 2 outputs, all registered with exactly 2 cycles of latency from stage 0:
  - PIXEL = shift[0] when active, else 0. LSB is the leftmost pixel.
  - DE = delayed active0.
  - HSYNC/VSYNC = SYNC_POL when the delayed hs0/vs0 is set, else !SYNC_POL.
  - VBLANK = delayed (v >= V_ACTIVE).
  - FRAME_START = delayed (h==0 && v==0).
- Read bandwidth: at most 1 read per 32 cycles; exactly WPL per active line; none during blanking.
- Reset, any cycle including mid-frame:
  - Next edge sets h=v=0, row_addr=BASE_ADDR, N_OE=1, ADDR=0 and clears the pipeline and shift register.
  - Outputs go to DE=0, PIXEL=0, VBLANK=0, FRAME_START=0, HSYNC=VSYNC=!SYNC_POL.
  - The first cycle after release is h=0 v=0 with a fetch of BASE_ADDR. FRAME_START fires 2 cycles later.
- N_OE is never asserted with h[4:0]!=0 or outside the active region. The formal contract must check this.

Decomposition:
- Package vga_pkg: default timing localparams, derived H_TOTAL/V_TOTAL/WPL, and a timing-position struct {h, v, active, hs, vs}.
- Sub-module vga_timing: h/v counters and stage-0 flag generation.
- vga_scanout instantiates vga_timing and implements fetch, the shift register and the output pipeline.

Test Plan:
- Reset: hold N_RST 3 cycles -> HSYNC=VSYNC=1, DE=0, N_OE=1, ADDR=0. Release -> first cycle N_OE=0 ADDR=0; FRAME_START=1 exactly 2 cycles later.
- Timing: free-run -> HSYNC low for 96 cycles starting 2 cycles after h=656, period 800. VSYNC low for lines 490-491. FRAME_START period 420000 cycles.
- Pixel data: VRAM word0=0x00000001, word1=0x80000000, others 0 -> PIXEL=1 only at row 0, columns 0 and 63. DE high for 640 cycles per line on 480 lines.
- Addressing:
  - Row 1 first fetch ADDR=20; last fetch of frame ADDR=9599; next frame first fetch ADDR=0.
  - With BASE_ADDR=100: first fetch 100, last 9699.
- Mid-frame reset at v=200 h=300 -> outputs at reset values the next cycle; raster restarts at h=0 v=0 with ADDR=0.
- Bandwidth: count N_OE=0 -> 20 per active line, 0 in blanking lines, 9600 per frame; never two within 32 cycles.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing defaults and pipeline bundles for the VGA scanout path.
package vga_pkg;

  localparam int H_ACTIVE_D  = 640;
  localparam int H_FP_D      = 16;
  localparam int H_SYNC_D    = 96;
  localparam int H_BP_D      = 48;
  localparam int V_ACTIVE_D  = 480;
  localparam int V_FP_D      = 10;
  localparam int V_SYNC_D    = 2;
  localparam int V_BP_D      = 33;
  localparam bit SYNC_POL_D  = 1'b0;
  localparam int BASE_ADDR_D = 0;

  localparam int H_TOTAL_D =
    H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int V_TOTAL_D =
    V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;
  localparam int WPL_D = H_ACTIVE_D / 32;

  localparam int CW = 12;
  localparam int AW = 14;

  typedef struct packed {
    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic          active;
    logic          hs;
    logic          vs;
  } pos_t;

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic vb;
    logic fs;
    logic load;
  } s1_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic pix;
    logic vb;
    logic fs;
  } out_t;

endpackage

// File: rtl/vga_scanout_if.sv
// VRAM read port between the scanout engine and the frame store.
interface vga_scanout_if;
  import vga_pkg::*;

  logic [AW-1:0] ADDR;
  logic          N_OE;
  logic [31:0]   RD_DATA;

  modport master (
    output ADDR,
    output N_OE,
    input  RD_DATA
  );

  modport slave (
    input  ADDR,
    input  N_OE,
    output RD_DATA
  );
endinterface

// File: rtl/vga_timing.sv
// Raster position counters and the stage-0 active/sync flags.
module vga_timing import vga_pkg::*; #(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D
) (
  input  logic CLK,
  input  logic N_RST,
  output pos_t pos
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_ON  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_OFF = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_ON  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_OFF = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] h_d, h_q;
  logic [CW-1:0] v_d, v_q;

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (N_RST) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  always_comb begin
    pos        = '0;
    pos.h      = h_q;
    pos.v      = v_q;
    pos.active = (h_q < H_ACT) && (v_q < V_ACT);
    pos.hs     = (h_q >= HS_ON) && (h_q < HS_OFF);
    pos.vs     = (v_q >= VS_ON) && (v_q < VS_OFF);
  end

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: raster timing, VRAM word fetch and 1 bpp serialiser.
// Video outputs lag the stage-0 counters by exactly two pixel clocks.
module vga_scanout import vga_pkg::*; #(
  parameter int H_ACTIVE  = H_ACTIVE_D,
  parameter int H_FP      = H_FP_D,
  parameter int H_SYNC    = H_SYNC_D,
  parameter int H_BP      = H_BP_D,
  parameter int V_ACTIVE  = V_ACTIVE_D,
  parameter int V_FP      = V_FP_D,
  parameter int V_SYNC    = V_SYNC_D,
  parameter int V_BP      = V_BP_D,
  parameter bit SYNC_POL  = SYNC_POL_D,
  parameter int BASE_ADDR = BASE_ADDR_D
) (
  input  logic          CLK,
  input  logic          N_RST,
  vga_scanout_if.master vram,
  output logic          HSYNC,
  output logic          VSYNC,
  output logic          DE,
  output logic          PIXEL,
  output logic          VBLANK,
  output logic          FRAME_START
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [AW-1:0] BASE   = AW'(BASE_ADDR);
  localparam logic [AW-1:0] WPL    = AW'(H_ACTIVE / 32);

  localparam out_t OUT_RST = '{
    hs: !SYNC_POL, vs: !SYNC_POL, default: 1'b0
  };

  pos_t          pos;
  logic          fetch0;
  logic          line_end;
  logic          frame_end;
  logic [AW-1:0] row_d, row_q;
  logic [AW-1:0] addr_d, addr_q;
  s1_t           s1_d, s1_q;
  logic [31:0]   src;
  logic [31:0]   shift_d, shift_q;
  out_t          s2_d, s2_q;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .CLK   (CLK),
    .N_RST (N_RST),
    .pos   (pos)
  );

  // Reset masks the strobe at once so the frame store is never read
  // while the raster is parked at (0,0).
  always_comb begin
    fetch0 = pos.active && (pos.h[4:0] == 5'd0) && !N_RST;
    line_end  = (pos.h == H_LAST) && (pos.v < V_ACT);
    frame_end = (pos.h == H_LAST) && (pos.v == V_LAST);
    unique case (1'b1)
      frame_end: row_d = BASE;
      line_end:  row_d = row_q + WPL;
      default:   row_d = row_q;
    endcase
    addr_d = fetch0 ? row_q + AW'(pos.h >> 5) : addr_q;
  end

  assign vram.ADDR = addr_d;
  assign vram.N_OE = !fetch0;

  // The word lands during stage 1, so pixel 0 bypasses the register.
  always_comb begin
    s1_d.act  = pos.active;
    s1_d.hs   = pos.hs;
    s1_d.vs   = pos.vs;
    s1_d.vb   = pos.v >= V_ACT;
    s1_d.fs   = (pos.h == '0) && (pos.v == '0);
    s1_d.load = fetch0;
    src       = s1_q.load ? vram.RD_DATA : shift_q;
    shift_d   = src >> 1;
    s2_d.hs   = s1_q.hs ? SYNC_POL : !SYNC_POL;
    s2_d.vs   = s1_q.vs ? SYNC_POL : !SYNC_POL;
    s2_d.de   = s1_q.act;
    s2_d.pix  = s1_q.act && src[0];
    s2_d.vb   = s1_q.vb;
    s2_d.fs   = s1_q.fs;
  end

  always_ff @(posedge CLK) begin
    if (N_RST) begin
      row_q   <= BASE;
      addr_q  <= '0;
      s1_q    <= '0;
      shift_q <= '0;
      s2_q    <= OUT_RST;
    end else begin
      row_q   <= row_d;
      addr_q  <= addr_d;
      s1_q    <= s1_d;
      shift_q <= shift_d;
      s2_q    <= s2_d;
    end
  end

  assign HSYNC       = s2_q.hs;
  assign VSYNC       = s2_q.vs;
  assign DE          = s2_q.de;
  assign PIXEL       = s2_q.pix;
  assign VBLANK      = s2_q.vb;
  assign FRAME_START = s2_q.fs;

  a_fetch_slot: assert property (
    @(posedge CLK) !vram.N_OE |->
      (pos.active && pos.h[4:0] == 5'd0)
  );

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench: two shrunken rasters plus one at full 640x480 timing.
module tb_vga_scanout;

  localparam int HA = 64;
  localparam int HF = 8;
  localparam int HS = 16;
  localparam int HB = 8;
  localparam int VA = 4;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int WPL = HA / 32;
  localparam int FRAME = HT * VT;
  localparam logic [11:0] RST = 12'b110000_000000;

  logic CLK = 1'b0;
  logic N_RST = 1'b1;
  always #5 CLK = ~CLK;

  vga_scanout_if vif_a ();
  vga_scanout_if vif_b ();
  vga_scanout_if vif_f ();

  logic hs_a, vs_a, de_a, px_a, vb_a, fs_a;
  logic hs_b, vs_b, de_b, px_b, vb_b, fs_b;
  logic hs_f, vs_f, de_f, px_f, vb_f, fs_f;
  logic [11:0] outs;

  assign outs = {hs_a, vs_a, de_a, px_a, vb_a, fs_a,
                 hs_b, vs_b, de_b, px_b, vb_b, fs_b};

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .BASE_ADDR(0)
  ) u_a (
    .CLK(CLK), .N_RST(N_RST), .vram(vif_a.master),
    .HSYNC(hs_a), .VSYNC(vs_a), .DE(de_a),
    .PIXEL(px_a), .VBLANK(vb_a), .FRAME_START(fs_a)
  );

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1), .BASE_ADDR(100)
  ) u_b (
    .CLK(CLK), .N_RST(N_RST), .vram(vif_b.master),
    .HSYNC(hs_b), .VSYNC(vs_b), .DE(de_b),
    .PIXEL(px_b), .VBLANK(vb_b), .FRAME_START(fs_b)
  );

  vga_scanout u_f (
    .CLK(CLK), .N_RST(N_RST), .vram(vif_f.master),
    .HSYNC(hs_f), .VSYNC(vs_f), .DE(de_f),
    .PIXEL(px_f), .VBLANK(vb_f), .FRAME_START(fs_f)
  );

  function automatic logic [31:0] word_a(input int a);
    if (a == 0) return 32'h0000_0001;
    if (a == 1) return 32'h8000_0000;
    return 32'h0;
  endfunction

  function automatic logic [31:0] word_b(input int a);
    return 32'h5A3C_96E1 ^ (32'(a) * 32'h9E37_79B9);
  endfunction

  always @(posedge CLK) begin
    if (!vif_a.N_OE) vif_a.RD_DATA <= word_a(int'(vif_a.ADDR));
    if (!vif_b.N_OE) vif_b.RD_DATA <= word_b(int'(vif_b.ADDR));
    if (!vif_f.N_OE) vif_f.RD_DATA <= word_a(int'(vif_f.ADDR));
  end

  // Expected {hs,vs,de,pix,vb,fs} two cycles after raster (h,v).
  function automatic logic [5:0] model(
    input int h, input int v, input bit pol,
    input bit sel, input int base
  );
    bit act, hsn, vsn, pix;
    logic [31:0] w;
    int a;
    act = (h < HA) && (v < VA);
    hsn = (h >= HA + HF) && (h < HA + HF + HS);
    vsn = (v >= VA + VF) && (v < VA + VF + VS);
    a = base + v * WPL + h / 32;
    w = sel ? word_b(a) : word_a(a);
    pix = act && w[h % 32];
    return {hsn ? pol : !pol, vsn ? pol : !pol,
            act, pix, v >= VA, (h == 0) && (v == 0)};
  endfunction

  int checks = 0;
  int failures = 0;
  int mh, mv, n;
  int rd_a, rd_b, last_a, last_b, last_fs;
  int de_cnt, px_cnt;
  logic [11:0] q_out[$];
  int q_addr_a[$];
  int q_addr_b[$];

  task automatic check(
    input string tag, input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_model();
    mh = 0; mv = 0; n = 0;
    q_out.delete();
    q_out.push_back(RST);
    q_out.push_back(RST);
    q_addr_a.delete();
    q_addr_b.delete();
    rd_a = 0; rd_b = 0;
    last_a = -32; last_b = -32; last_fs = -1;
    de_cnt = 0; px_cnt = 0;
  endtask

  task automatic reset_checks(input string t);
    check({t, "_out"}, 32'(outs), 32'(RST));
    check({t, "_noe_a"}, 32'(vif_a.N_OE), 32'd1);
    check({t, "_addr_a"}, 32'(vif_a.ADDR), 32'd0);
    check({t, "_noe_b"}, 32'(vif_b.N_OE), 32'd1);
    check({t, "_addr_b"}, 32'(vif_b.ADDR), 32'd0);
    check({t, "_noe_f"}, 32'(vif_f.N_OE), 32'd1);
    check({t, "_addr_f"}, 32'(vif_f.ADDR), 32'd0);
    check({t, "_sync_f"}, 32'({hs_f, vs_f, de_f}), 32'b110);
  endtask

  task automatic release_checks(input string t);
    check({t, "_noe_a"}, 32'(vif_a.N_OE), 32'd0);
    check({t, "_addr_a"}, 32'(vif_a.ADDR), 32'd0);
    check({t, "_noe_b"}, 32'(vif_b.N_OE), 32'd0);
    check({t, "_addr_b"}, 32'(vif_b.ADDR), 32'd100);
    check({t, "_addr_f"}, 32'(vif_f.ADDR), 32'd0);
  endtask

  task automatic sample();
    bit fetch;
    logic [11:0] e;
    fetch = (mh < HA) && (mv < VA) && (mh % 32 == 0);
    q_out.push_back({model(mh, mv, 1'b0, 1'b0, 0),
                     model(mh, mv, 1'b1, 1'b1, 100)});
    e = q_out.pop_front();
    check("out", 32'(outs), 32'(e));
    check("noe_a", 32'(vif_a.N_OE), 32'(!fetch));
    check("noe_b", 32'(vif_b.N_OE), 32'(!fetch));
    if (fetch) begin
      q_addr_a.push_back(mv * WPL + mh / 32);
      q_addr_b.push_back(100 + mv * WPL + mh / 32);
    end
    if (!vif_a.N_OE) begin
      check("gap_a", 32'(n - last_a >= 32), 32'd1);
      check("addrq_a", 32'(q_addr_a.size()), 32'd1);
      if (q_addr_a.size() > 0)
        check("addr_a", 32'(vif_a.ADDR), 32'(q_addr_a.pop_front()));
      rd_a++;
      last_a = n;
    end
    if (!vif_b.N_OE) begin
      check("gap_b", 32'(n - last_b >= 32), 32'd1);
      check("addrq_b", 32'(q_addr_b.size()), 32'd1);
      if (q_addr_b.size() > 0)
        check("addr_b", 32'(vif_b.ADDR), 32'(q_addr_b.pop_front()));
      rd_b++;
      last_b = n;
    end
    if (de_a) de_cnt++;
    if (px_a) px_cnt++;
    if (fs_a) begin
      if (last_fs >= 0) check("fs_period", 32'(n - last_fs), 32'(FRAME));
      last_fs = n;
    end
    if (mh == HT - 1 && mv == VT - 1) begin
      check("reads_a", 32'(rd_a), 32'(VA * WPL));
      check("reads_b", 32'(rd_b), 32'(VA * WPL));
      check("de_cnt", 32'(de_cnt), 32'(HA * VA));
      check("px_cnt", 32'(px_cnt), 32'd2);
      rd_a = 0; rd_b = 0; de_cnt = 0; px_cnt = 0;
    end
    case (n)
      32: check("f_addr32", 32'({vif_f.N_OE, vif_f.ADDR}), 32'd1);
      641: check("f_de641", 32'(de_f), 32'd1);
      642: check("f_de642", 32'(de_f), 32'd0);
      657: check("f_hs657", 32'(hs_f), 32'd1);
      658: check("f_hs658", 32'(hs_f), 32'd0);
      672: check("f_noe672", 32'(vif_f.N_OE), 32'd1);
      753: check("f_hs753", 32'(hs_f), 32'd0);
      754: check("f_hs754", 32'(hs_f), 32'd1);
      800: check("f_addr800", 32'({vif_f.N_OE, vif_f.ADDR}), 32'd20);
      801: check("f_noe801", 32'(vif_f.N_OE), 32'd1);
      1600: check("f_addr1600", 32'({vif_f.N_OE, vif_f.ADDR}), 32'd40);
      default: ;
    endcase
  endtask

  task automatic advance();
    @(posedge CLK);
    #1;
    n++;
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
  endtask

  initial begin
    int guard;
    repeat (3) @(posedge CLK);
    #1;
    reset_checks("rst");
    N_RST = 1'b0;
    #1;
    release_checks("rel");
    start_model();
    repeat (2 * FRAME) begin
      sample();
      advance();
    end
    guard = 0;
    while (!(mv == 2 && mh == 30) && guard < FRAME) begin
      sample();
      advance();
      guard++;
    end
    check("mid_pos", 32'(guard), 32'(2 * HT + 30));
    N_RST = 1'b1;
    @(posedge CLK);
    #1;
    reset_checks("mid");
    N_RST = 1'b0;
    #1;
    release_checks("mrel");
    start_model();
    repeat (FRAME + HT) begin
      sample();
      advance();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
